chip8_display_buffer: RTL and testbench

// - Per-chip 64x32 1bpp CHIP-8 framebuffer: 256 bytes, 8 px/byte, MSB = leftmost pixel.
// - Upstream of the video multiplexer. It serves that block's byte reads on a dedicated port with a fixed 3-cycle latency.
// - Executes CLS and DXYN for the CHIP-8 core on a second port: XOR sprite read-modify-write with VF collision reporting.

---
 rtl/chip8_pkg.sv | 8 +
 rtl/chip8_display_buffer_fb_bram.sv | 24 ++
 rtl/chip8_display_buffer.sv | 174 +++++++++++++++++
 tb/tb_chip8_display_buffer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// chip8_pkg: framebuffer geometry and draw/clear FSM states shared by the display buffer.
package chip8_pkg;
  localparam int FB_W = 64;
  localparam int FB_H = 32;
  localparam int FB_BYTES = 256;
  localparam int FB_ADDR_W = 8;
  typedef enum logic [2:0] {CLEAR, IDLE, ROW, RD, WAIT, WR, DONE} fb_state_t;
endpackage

// File: rtl/chip8_display_buffer_fb_bram.sv
// fb_bram: 256x8 dual-port RAM, port A read/write, port B read-only, 2-cycle registered reads.
module fb_bram
  import chip8_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 a_we_in,
  input  logic [FB_ADDR_W-1:0] a_addr_in,
  input  logic [7:0]           a_wdata_in,
  output logic [7:0]           a_rdata_out,
  input  logic [FB_ADDR_W-1:0] b_addr_in,
  output logic [7:0]           b_rdata_out
);
  logic [7:0] mem [FB_BYTES];
  logic [7:0] a1_q, a2_q, b1_q, b2_q;
  always_ff @(posedge clk_in) begin
    if (a_we_in) mem[a_addr_in] <= a_wdata_in;
    a1_q <= mem[a_addr_in];
    b1_q <= mem[b_addr_in];
    a2_q <= a1_q;
    b2_q <= b1_q;
  end
  assign a_rdata_out = a2_q;
  assign b_rdata_out = b2_q;
endmodule

// File: rtl/chip8_display_buffer.sv
// chip8_display_buffer: 64x32 1bpp CHIP-8 framebuffer with CLS/DXYN engine and a 3-cycle video read port.
module chip8_display_buffer
  import chip8_pkg::*;
#(
  parameter bit CLIP = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        clear_in,
  input  logic        draw_valid_in,
  output logic        draw_ready_out,
  input  logic [7:0]  draw_x_in,
  input  logic [7:0]  draw_y_in,
  input  logic [3:0]  draw_n_in,
  input  logic        sprite_valid_in,
  output logic        sprite_ready_out,
  input  logic [7:0]  sprite_data_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        collision_out,
  input  logic [15:0] hdmi_addr_in,
  output logic [7:0]  hdmi_data_out
);
  fb_state_t state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [4:0] y0_q, y0_d;
  logic [2:0] shift_q, shift_d, col_q, col_d;
  logic [3:0] rows_q, rows_d, row_q, row_d;
  logic [7:0] spr_q, spr_d, hdmi_q, hdmi_d;
  logic coll_q, coll_d, half_q, half_d;
  logic draw_ready_q, draw_ready_d, sprite_ready_q, sprite_ready_d;
  logic busy_q, busy_d, done_q, done_d, collision_q, collision_d;
  logic a_we;
  logic [7:0] a_addr, a_wdata, a_rdata, b_rdata;
  logic [5:0] y;
  logic [7:0] addr_l, addr_r, new_l, new_r, cur_new;
  logic need_r, last;
  logic unused_hi;
  assign unused_hi = ^hdmi_addr_in[15:8];
  fb_bram u_ram (
    .clk_in     (clk_in),
    .a_we_in    (a_we),
    .a_addr_in  (a_addr),
    .a_wdata_in (a_wdata),
    .a_rdata_out(a_rdata),
    .b_addr_in  (hdmi_addr_in[7:0]),
    .b_rdata_out(b_rdata)
  );
  // A sprite row straddles at most two bytes: L at col, R at col+1.
  assign y       = {1'b0, y0_q} + {2'b0, row_q};
  assign addr_l  = {y[4:0], col_q};
  assign addr_r  = {y[4:0], col_q + 3'd1};
  assign new_l   = spr_q >> shift_q;
  assign new_r   = spr_q << (4'd8 - {1'b0, shift_q});
  assign need_r  = (shift_q != 3'd0) && !(CLIP && col_q == 3'd7);
  assign last    = (row_q + 4'd1) == rows_q;
  assign cur_new = half_q ? new_r : new_l;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y0_d    = y0_q;
    shift_d = shift_q;
    col_d   = col_q;
    rows_d  = rows_q;
    row_d   = row_q;
    spr_d   = spr_q;
    coll_d  = coll_q;
    half_d  = half_q;
    a_we    = 1'b0;
    a_addr  = addr_l;
    a_wdata = a_rdata ^ cur_new;
    case (state_q)
      CLEAR: begin
        a_we    = !cnt_q[8];
        a_addr  = cnt_q[7:0];
        a_wdata = 8'h00;
        cnt_d   = cnt_q + 9'd1;
        state_d = cnt_q[8] ? DONE : CLEAR;
      end
      IDLE: begin
        if (clear_in) begin
          state_d = CLEAR;
          cnt_d   = 9'd0;
        end else if (draw_valid_in) begin
          y0_d    = draw_y_in[4:0];
          shift_d = draw_x_in[2:0];
          col_d   = draw_x_in[5:3];
          rows_d  = draw_n_in;
          row_d   = 4'd0;
          coll_d  = 1'b0;
          half_d  = 1'b0;
          state_d = (draw_n_in == 4'd0) ? DONE : ROW;
        end
      end
      ROW: begin
        if (sprite_valid_in) begin
          spr_d = sprite_data_in;
          // Rows below the screen are consumed but never touch RAM when clipping.
          if (CLIP && y[5]) begin
            row_d   = row_q + 4'd1;
            state_d = last ? DONE : ROW;
          end else state_d = RD;
        end
      end
      RD: state_d = WAIT;
      WAIT: begin
        a_addr  = addr_r;
        state_d = WR;
      end
      WR: begin
        a_we   = 1'b1;
        a_addr = half_q ? addr_r : addr_l;
        coll_d = coll_q | (|(a_rdata & cur_new));
        if (!half_q && need_r) half_d = 1'b1;
        else begin
          half_d  = 1'b0;
          row_d   = row_q + 4'd1;
          state_d = last ? DONE : ROW;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    draw_ready_d   = state_d == IDLE;
    sprite_ready_d = state_d == ROW;
    busy_d         = !(state_d == IDLE || state_d == DONE);
    done_d         = state_d == DONE;
    collision_d    = (state_d == DONE) ? ((state_q != CLEAR) & coll_d) : collision_q;
    hdmi_d         = b_rdata;
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= CLEAR;
      cnt_q          <= 9'd0;
      y0_q           <= 5'd0;
      shift_q        <= 3'd0;
      col_q          <= 3'd0;
      rows_q         <= 4'd0;
      row_q          <= 4'd0;
      spr_q          <= 8'd0;
      coll_q         <= 1'b0;
      half_q         <= 1'b0;
      draw_ready_q   <= 1'b0;
      sprite_ready_q <= 1'b0;
      busy_q         <= 1'b1;
      done_q         <= 1'b0;
      collision_q    <= 1'b0;
      hdmi_q         <= 8'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      y0_q           <= y0_d;
      shift_q        <= shift_d;
      col_q          <= col_d;
      rows_q         <= rows_d;
      row_q          <= row_d;
      spr_q          <= spr_d;
      coll_q         <= coll_d;
      half_q         <= half_d;
      draw_ready_q   <= draw_ready_d;
      sprite_ready_q <= sprite_ready_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      collision_q    <= collision_d;
      hdmi_q         <= hdmi_d;
    end
  end
  assign draw_ready_out   = draw_ready_q;
  assign sprite_ready_out = sprite_ready_q;
  assign busy_out         = busy_q;
  assign done_out         = done_q;
  assign collision_out    = collision_q;
  assign hdmi_data_out    = hdmi_q;
endmodule

// File: tb/tb_chip8_display_buffer.sv
// tb_chip8_display_buffer: directed checks of clear, draw, clipping/wrap and video reads on CLIP=1 and CLIP=0 instances.
module tb_chip8_display_buffer;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, dv = 1'b0, sv = 1'b0;
  logic [7:0] dx = 8'd0, dy = 8'd0, sd = 8'd0;
  logic [3:0] dn = 4'd0;
  logic [15:0] ha = 16'd0;
  logic dr0, sr0, busy0, done0, coll0, dr1, sr1, busy1, done1, coll1;
  logic [7:0] hd0, hd1, q0, q1;
  int n_chk = 0, n_pass = 0, cyc0 = 0, cyc1 = 0, e0 = 0, e1 = 0;
  logic seen0, seen1, srs, bz0;
  always #5 clk = ~clk;
  chip8_display_buffer #(.CLIP(1'b1)) u0 (
    .clk_in(clk), .rst_in(rst), .clear_in(clear), .draw_valid_in(dv), .draw_ready_out(dr0),
    .draw_x_in(dx), .draw_y_in(dy), .draw_n_in(dn), .sprite_valid_in(sv), .sprite_ready_out(sr0),
    .sprite_data_in(sd), .busy_out(busy0), .done_out(done0), .collision_out(coll0),
    .hdmi_addr_in(ha), .hdmi_data_out(hd0));
  chip8_display_buffer #(.CLIP(1'b0)) u1 (
    .clk_in(clk), .rst_in(rst), .clear_in(clear), .draw_valid_in(dv), .draw_ready_out(dr1),
    .draw_x_in(dx), .draw_y_in(dy), .draw_n_in(dn), .sprite_valid_in(sv), .sprite_ready_out(sr1),
    .sprite_data_in(sd), .busy_out(busy1), .done_out(done1), .collision_out(coll1),
    .hdmi_addr_in(ha), .hdmi_data_out(hd1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic wait_done();
    int k = 0;
    seen0 = 1'b0; seen1 = 1'b0; srs = 1'b0; bz0 = 1'b1;
    while (!(seen0 && seen1) && k < 400) begin
      @(negedge clk);
      k++; dv = 1'b0; clear = 1'b0;
      if (sr0) srs = 1'b1;
      if (done0 && !seen0) begin seen0 = 1'b1; cyc0 = k; bz0 = busy0; end
      if (done1 && !seen1) begin seen1 = 1'b1; cyc1 = k; end
    end
    chk("done_seen", {30'd0, seen0, seen1}, 32'd3);
  endtask
  task automatic draw(input logic [7:0] x, input logic [7:0] y, input logic [3:0] n, input logic [7:0] d);
    @(negedge clk);
    dx = x; dy = y; dn = n; sd = d; dv = 1'b1; sv = 1'b1;
    wait_done();
    sv = 1'b0;
  endtask
  task automatic rd(input logic [7:0] a, output logic [7:0] r0, output logic [7:0] r1);
    @(negedge clk) ha = {8'h5A, a};
    @(negedge clk) ha = {8'hC3, a ^ 8'h01};
    repeat (2) @(negedge clk);
    r0 = hd0; r1 = hd1;
  endtask
  task automatic sweep(input string tag);
    e0 = 0; e1 = 0;
    for (int i = 0; i < 259; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        if (hd0 !== 8'h00) e0++;
        if (hd1 !== 8'h00) e1++;
      end
      if (i < 256) ha = {8'hA5, 8'(i)};
    end
    chk({tag, "_u0"}, e0, 0);
    chk({tag, "_u1"}, e1, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int rows = 0, k = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 1);
    chk("rst_dready", dr0, 0);
    chk("rst_sready", sr0, 0);
    chk("rst_done", done0, 0);
    chk("rst_coll", coll0, 0);
    chk("rst_hdmi", hd0, 0);
    rst = 1'b0;
    wait_done();
    chk("clr_cycles", cyc0, 257);
    chk("clr_busy_at_done", bz0, 0);
    chk("clr_coll", coll0, 0);
    sweep("clr_sweep");
    draw(8'd0, 8'd0, 4'd1, 8'hF0);
    rd(8'h00, q0, q1);
    chk("f0_u0", q0, 8'hF0);
    chk("f0_u1", q1, 8'hF0);
    chk("f0_coll", coll0, 0);
    chk("f0_busy_at_done", bz0, 0);
    draw(8'd0, 8'd0, 4'd1, 8'hF0);
    rd(8'h00, q0, q1);
    chk("f0b_u0", q0, 8'h00);
    chk("f0b_u1", q1, 8'h00);
    chk("f0b_coll_u0", coll0, 1);
    chk("f0b_coll_u1", coll1, 1);
    draw(8'd70, 8'd0, 4'd0, 8'hAA);
    chk("n0_cycles", cyc0, 1);
    chk("n0_sready", srs, 0);
    chk("n0_coll", coll0, 0);
    draw(8'd3, 8'd5, 4'd1, 8'hFF);
    chk("x3_bound", cyc0 <= 12, 1);
    chk("x3_coll", coll0, 0);
    rd(8'h28, q0, q1);
    chk("x3_28", q0, 8'h1F);
    rd(8'h29, q0, q1);
    chk("x3_29", q0, 8'hE0);
    draw(8'd62, 8'd31, 4'd2, 8'hFF);
    chk("edge_bound_u0", cyc0 <= 20, 1);
    chk("edge_bound_u1", cyc1 <= 20, 1);
    chk("edge_coll_u1", coll1, 0);
    rd(8'hFF, q0, q1);
    chk("edge_ff_u0", q0, 8'h03);
    chk("edge_ff_u1", q1, 8'h03);
    rd(8'hF8, q0, q1);
    chk("edge_f8_u0", q0, 8'h00);
    chk("edge_f8_u1", q1, 8'hFC);
    rd(8'h07, q0, q1);
    chk("edge_07_u0", q0, 8'h00);
    chk("edge_07_u1", q1, 8'h03);
    rd(8'h00, q0, q1);
    chk("edge_00_u0", q0, 8'h00);
    chk("edge_00_u1", q1, 8'hFC);
    @(negedge clk);
    clear = 1'b1; dv = 1'b1; dx = 8'd0; dy = 8'd0; dn = 4'd1; sd = 8'hFF; sv = 1'b1;
    wait_done();
    sv = 1'b0;
    chk("cls_wins_cycles", cyc0, 258);
    chk("cls_wins_sready", srs, 0);
    sweep("cls_sweep");
    draw(8'd0, 8'd0, 4'd1, 8'hF0);
    draw(8'd0, 8'd0, 4'd1, 8'hF0);
    chk("pre_rst_coll", coll0, 1);
    @(negedge clk);
    dx = 8'd0; dy = 8'd0; dn = 4'd4; sd = 8'hFF; dv = 1'b1; sv = 1'b1;
    while (rows < 3 && k < 100) begin
      @(negedge clk);
      dv = 1'b0; k++;
      if (sr0) rows++;
    end
    chk("mid_row2_reached", rows, 3);
    rst = 1'b1; sv = 1'b0;
    #1;
    chk("mid_busy", busy0, 1);
    chk("mid_sready", sr0, 0);
    chk("mid_dready", dr0, 0);
    chk("mid_done", done0, 0);
    chk("mid_coll", coll0, 0);
    chk("mid_hdmi", hd0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_done();
    chk("mid_clr_cycles", cyc0, 257);
    sweep("mid_sweep");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
